// File: rtl/alu_ex_mem.sv
// Execute-stage ALU feeding the EX/MEM pipeline latch.
// Holds the latch on stall and loads a bubble on flush.
module alu_ex_mem #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_CTRL = 4,
    parameter int unsigned NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_CTRL-1:0] i_alu_ctrl,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_REG-1:0]  i_shamt,
    input  logic [NB_DATA-1:0] i_store_data,
    input  logic [NB_REG-1:0]  i_rd_addr,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic [NB_DATA-1:0] o_store_data,
    output logic [NB_REG-1:0]  o_rd_addr,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_valid
);

    localparam logic [NB_CTRL-1:0] ALU_ADD  = 4'h0;
    localparam logic [NB_CTRL-1:0] ALU_AND  = 4'h1;
    localparam logic [NB_CTRL-1:0] ALU_NOR  = 4'h2;
    localparam logic [NB_CTRL-1:0] ALU_OR   = 4'h3;
    localparam logic [NB_CTRL-1:0] ALU_SLL  = 4'h4;
    localparam logic [NB_CTRL-1:0] ALU_SRL  = 4'h5;
    localparam logic [NB_CTRL-1:0] ALU_SRA  = 4'h6;
    localparam logic [NB_CTRL-1:0] ALU_SUB  = 4'h7;
    localparam logic [NB_CTRL-1:0] ALU_XOR  = 4'h8;
    localparam logic [NB_CTRL-1:0] ALU_SRAV = 4'h9;
    localparam logic [NB_CTRL-1:0] ALU_SRLV = 4'hA;
    localparam logic [NB_CTRL-1:0] ALU_SLLV = 4'hB;
    localparam logic [NB_CTRL-1:0] ALU_SLT  = 4'hC;
    localparam logic [NB_CTRL-1:0] ALU_LUI  = 4'hD;

    localparam int unsigned NB_HALF = NB_DATA / 2;

    logic [NB_DATA-1:0] alu_result;
    logic [NB_REG-1:0]  var_shamt;
    logic               slt;

    assign var_shamt = i_data_a[NB_REG-1:0];
    assign slt       = $signed(i_data_a) < $signed(i_data_b);

    always_comb begin
        alu_result = i_data_a + i_data_b;
        case (i_alu_ctrl)
            ALU_ADD:  alu_result = i_data_a + i_data_b;
            ALU_AND:  alu_result = i_data_a & i_data_b;
            ALU_NOR:  alu_result = ~(i_data_a | i_data_b);
            ALU_OR:   alu_result = i_data_a | i_data_b;
            ALU_SLL:  alu_result = i_data_b << i_shamt;
            ALU_SRL:  alu_result = i_data_b >> i_shamt;
            ALU_SRA:  alu_result = $signed(i_data_b) >>> i_shamt;
            ALU_SUB:  alu_result = i_data_a - i_data_b;
            ALU_XOR:  alu_result = i_data_a ^ i_data_b;
            ALU_SRAV: alu_result = $signed(i_data_b) >>> var_shamt;
            ALU_SRLV: alu_result = i_data_b >> var_shamt;
            ALU_SLLV: alu_result = i_data_b << var_shamt;
            ALU_SLT:  alu_result = {{(NB_DATA-1){1'b0}}, slt};
            ALU_LUI:  alu_result = {i_data_b[NB_HALF-1:0], {NB_HALF{1'b0}}};
            // Unused codes fall back to ADD.
            default:  alu_result = i_data_a + i_data_b;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            o_result     <= '0;
            o_zero       <= 1'b0;
            o_store_data <= '0;
            o_rd_addr    <= '0;
            o_reg_write  <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_valid      <= 1'b0;
        end else if (!i_stall) begin
            o_result     <= alu_result;
            o_zero       <= (alu_result == '0);
            o_store_data <= i_store_data;
            o_rd_addr    <= i_rd_addr;
            // Invalid slots still capture data but carry no side effects.
            o_reg_write  <= i_reg_write & i_valid;
            o_mem_read   <= i_mem_read & i_valid;
            o_mem_write  <= i_mem_write & i_valid;
            o_valid      <= i_valid;
        end
    end

endmodule

// File: tb/tb_alu_ex_mem.sv
// Self-checking bench for alu_ex_mem: vector table, directed latch sequences
// and randomized traffic against a behavioural model.
module tb_alu_ex_mem;

    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_CTRL = 4;
    localparam int unsigned NB_REG  = 5;
    localparam int unsigned NB_OUT  = 2 * NB_DATA + NB_REG + 5;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic [NB_CTRL-1:0] i_alu_ctrl;
    logic [NB_DATA-1:0] i_data_a, i_data_b, i_store_data;
    logic [NB_REG-1:0]  i_shamt, i_rd_addr;
    logic               i_reg_write, i_mem_read, i_mem_write, i_valid, i_stall, i_flush;
    logic [NB_DATA-1:0] o_result, o_store_data;
    logic [NB_REG-1:0]  o_rd_addr;
    logic               o_zero, o_reg_write, o_mem_read, o_mem_write, o_valid;

    always #5 i_clk = ~i_clk;

    alu_ex_mem #(.NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL), .NB_REG(NB_REG)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_alu_ctrl(i_alu_ctrl),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_shamt(i_shamt),
        .i_store_data(i_store_data), .i_rd_addr(i_rd_addr),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
        .o_result(o_result), .o_zero(o_zero), .o_store_data(o_store_data),
        .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_valid(o_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [NB_OUT-1:0] exp_out;
    logic [NB_OUT-1:0] act_out;
    assign act_out = {o_result, o_zero, o_store_data, o_rd_addr,
                      o_reg_write, o_mem_read, o_mem_write, o_valid};

    task automatic check(input string name, input logic [NB_OUT-1:0] act,
                         input logic [NB_OUT-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference ALU written from the operation table.
    function automatic logic [NB_DATA-1:0] ref_alu(input logic [3:0] op,
            input logic [NB_DATA-1:0] a, input logic [NB_DATA-1:0] b, input int sh);
        int va;
        logic signed [NB_DATA-1:0] sb;
        va = int'(a % 32);
        sb = b;
        case (op)
            4'h1: return a & b;
            4'h2: return ~(a | b);
            4'h3: return a | b;
            4'h4: return b << sh;
            4'h5: return b >> sh;
            4'h6: return sb >>> sh;
            4'h7: return a - b;
            4'h8: return a ^ b;
            4'h9: return sb >>> va;
            4'hA: return b >> va;
            4'hB: return b << va;
            4'hC: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hD: return b * 32'h0001_0000;
            default: return a + b;
        endcase
    endfunction

    // Next latch contents from the priority rules: reset, flush, stall, capture.
    function automatic logic [NB_OUT-1:0] model_next(input logic [NB_OUT-1:0] cur);
        logic [NB_DATA-1:0] r;
        if (!i_reset || i_flush) return '0;
        if (i_stall) return cur;
        r = ref_alu(i_alu_ctrl, i_data_a, i_data_b, int'(i_shamt));
        return {r, r == 0, i_store_data, i_rd_addr, i_reg_write && i_valid,
                i_mem_read && i_valid, i_mem_write && i_valid, i_valid};
    endfunction

    task automatic tick(input string name);
        exp_out = model_next(exp_out);
        @(posedge i_clk);
        #1;
        check(name, act_out, exp_out);
    endtask

    task automatic set_op(input logic [3:0] op, input logic [NB_DATA-1:0] a,
                          input logic [NB_DATA-1:0] b, input logic [NB_REG-1:0] sh);
        i_alu_ctrl = op; i_data_a = a; i_data_b = b; i_shamt = sh;
    endtask

    typedef struct {
        logic [3:0]         op;
        logic [NB_DATA-1:0] a;
        logic [NB_DATA-1:0] b;
        logic [NB_REG-1:0]  sh;
        logic [NB_DATA-1:0] res;
        logic               zero;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'h7, 32'd3,          32'd3,          5'd0, 32'd0,          1'b1};
        vecs[1] = '{4'h0, 32'hFFFF_FFFF,  32'd1,          5'd0, 32'd0,          1'b1};
        vecs[2] = '{4'hC, 32'hFFFF_FFFF,  32'd1,          5'd0, 32'd1,          1'b0};
        vecs[3] = '{4'hC, 32'd1,          32'hFFFF_FFFF,  5'd0, 32'd0,          1'b1};
        vecs[4] = '{4'h6, 32'd0,          32'h8000_0000,  5'd4, 32'hF800_0000,  1'b0};
        vecs[5] = '{4'h5, 32'd0,          32'h8000_0000,  5'd4, 32'h0800_0000,  1'b0};
        vecs[6] = '{4'hB, 32'h24,         32'd1,          5'd0, 32'h10,         1'b0};
        vecs[7] = '{4'hD, 32'd0,          32'h0000_ABCD,  5'd0, 32'hABCD_0000,  1'b0};
        vecs[8] = '{4'hF, 32'd2,          32'd3,          5'd0, 32'd5,          1'b0};
        vecs[9] = '{4'h2, 32'h0F0F_0000,  32'h0000_00FF,  5'd0, 32'hF0F0_FF00,  1'b0};

        exp_out = '0;
        set_op(4'h0, 32'h1234, 32'h5678, 5'd3);
        i_store_data = 32'hDEAD_BEEF; i_rd_addr = 5'd9;
        i_reg_write = 1; i_mem_read = 1; i_mem_write = 1; i_valid = 1;
        i_stall = 0; i_flush = 0; i_reset = 0;

        // Reset with nonzero inputs.
        tick("reset0");
        tick("reset1");
        check("reset_zero", act_out, '0);

        i_reset = 1;
        i_mem_read = 0; i_mem_write = 0;
        set_op(4'h0, 32'd5, 32'd7, 5'd0);
        tick("add_first");
        check("add_5_7", {o_result, o_zero, o_valid}, {32'd12, 1'b0, 1'b1});

        foreach (vecs[k]) begin
            set_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].sh);
            tick("tbl_latch");
            check($sformatf("tbl%0d", k), {o_result, o_zero}, {vecs[k].res, vecs[k].zero});
        end

        // Stall holds the latch for three cycles while inputs change.
        set_op(4'h0, 32'd5, 32'd7, 5'd0);
        i_rd_addr = 5'd4; i_reg_write = 1;
        tick("stall_load");
        i_stall = 1;
        for (int c = 0; c < 3; c++) begin
            set_op(4'h8, $urandom, $urandom, 5'd1);
            i_rd_addr = 5'(c + 20); i_reg_write = 0; i_valid = 0;
            tick("stall_hold");
            check("stall_val", {o_result, o_rd_addr, o_reg_write, o_valid},
                  {32'd12, 5'd4, 1'b1, 1'b1});
        end
        i_stall = 0; i_valid = 1; i_reg_write = 1;
        set_op(4'h0, 32'd1, 32'd2, 5'd0);
        tick("stall_release");
        check("stall_release_val", {o_result, o_valid}, {32'd3, 1'b1});

        // Flush beats stall for a valid store.
        set_op(4'h0, 32'd100, 32'd8, 5'd0);
        i_reg_write = 0; i_mem_write = 1; i_valid = 1;
        i_flush = 1; i_stall = 1;
        tick("flush_stall");
        check("flush_val", {o_valid, o_mem_write, o_result}, '0);
        i_flush = 0; i_stall = 0;

        // Invalid slot: data captured, controls dropped.
        i_valid = 0; i_reg_write = 1; i_mem_read = 1; i_mem_write = 0;
        set_op(4'h0, 32'd1, 32'd1, 5'd0);
        tick("bubble");
        check("bubble_val", {o_valid, o_reg_write, o_mem_read, o_mem_write, o_result},
              {4'b0000, 32'd2});

        // Reset during a stall clears the latch.
        i_valid = 1;
        set_op(4'h3, 32'hF0, 32'h0F, 5'd0);
        tick("pre_rst");
        i_stall = 1; i_reset = 0;
        tick("rst_in_stall");
        check("rst_in_stall_zero", act_out, '0);
        i_stall = 0; i_reset = 1;

        for (int n = 0; n < 400; n++) begin
            set_op(4'($urandom), $urandom, $urandom, 5'($urandom));
            if ($urandom_range(0, 3) == 0) i_data_b = 0;
            i_store_data = $urandom; i_rd_addr = 5'($urandom);
            i_reg_write = 1'($urandom); i_mem_read = 1'($urandom);
            i_mem_write = 1'($urandom); i_valid = ($urandom_range(0, 4) != 0);
            i_stall = ($urandom_range(0, 4) == 0);
            i_flush = ($urandom_range(0, 9) == 0);
            i_reset = ($urandom_range(0, 29) != 0);
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
